// File: rtl/shiftbuffer_drain_pkg.sv
// Shared defaults for the shift-buffer drain slice.
// Holds parameter defaults only; widths are derived where used.
package shiftbuffer_drain_pkg;

   localparam int unsigned DEF_WIDTH = 32;
   localparam int unsigned DEF_PACK  = 2;
   localparam int unsigned DEF_DEPTH = 4;

endpackage

// File: rtl/shiftbuffer_drain_if.sv
// Stream bundle for the shift-buffer drain.
// Ports: upstream in/in_valid/o_stall, i_flush,
//        downstream out/out_cnt/out_valid/out_ready, o_level.
interface shiftbuffer_drain_if
   import shiftbuffer_drain_pkg::*;
#(
   parameter int unsigned p_width = DEF_WIDTH,
   parameter int unsigned p_pack  = DEF_PACK,
   parameter int unsigned p_depth = DEF_DEPTH
) ();

   localparam int unsigned CW = $clog2(p_pack + 1);
   localparam int unsigned LW = $clog2(p_depth + 1);

   logic [p_width-1:0]        in;
   logic                      in_valid;
   logic                      o_stall;
   logic                      i_flush;
   logic [p_width*p_pack-1:0] out;
   logic [CW-1:0]             out_cnt;
   logic                      out_valid;
   logic                      out_ready;
   logic [LW-1:0]             o_level;

   modport slave (
      input  in, in_valid, i_flush, out_ready,
      output o_stall, out, out_cnt, out_valid, o_level
   );

   modport master (
      output in, in_valid, i_flush, out_ready,
      input  o_stall, out, out_cnt, out_valid, o_level
   );

endinterface

// File: rtl/shiftbuffer_drain_beat_fifo.sv
// Synchronous show-ahead beat FIFO, sync active-low reset.
// Ports: i_push/i_data in, i_pop in, o_data head, o_count, o_empty.
module shiftbuffer_drain_beat_fifo
   import shiftbuffer_drain_pkg::*;
#(
   parameter int unsigned p_ew    = DEF_WIDTH,
   parameter int unsigned p_depth = DEF_DEPTH,
   localparam int unsigned LW = $clog2(p_depth + 1),
   localparam int unsigned PW = $clog2(p_depth)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_push,
   input  logic [p_ew-1:0] i_data,
   input  logic            i_pop,
   output logic [p_ew-1:0] o_data,
   output logic [LW-1:0]   o_count,
   output logic            o_empty
);

   logic [p_ew-1:0] mem_q [p_depth];
   logic [PW-1:0]   wr_q;
   logic [PW-1:0]   rd_q;
   logic [LW-1:0]   cnt_q;

   // depth need not be a power of two
   function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
      return (p == PW'(p_depth - 1)) ? '0 : p + 1'b1;
   endfunction

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         wr_q  <= '0;
         rd_q  <= '0;
         cnt_q <= '0;
      end else begin
         assert (!(i_push && !i_pop && cnt_q == LW'(p_depth)));
         assert (!(i_pop && cnt_q == '0));
         if (i_push) wr_q <= inc(wr_q);
         if (i_pop)  rd_q <= inc(rd_q);
         cnt_q <= cnt_q + LW'(i_push) - LW'(i_pop);
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_push) mem_q[wr_q] <= i_data;
   end

   assign o_data  = mem_q[rd_q];
   assign o_count = cnt_q;
   assign o_empty = (cnt_q == '0);

endmodule

// File: rtl/shiftbuffer_drain.sv
// Packs upstream words into wide beats, queues them, drains on valid/ready.
// Ports: i_clk, i_rst_n (sync, active-low), bus (slave modport).
module shiftbuffer_drain
   import shiftbuffer_drain_pkg::*;
#(
   parameter int unsigned p_width = DEF_WIDTH,
   parameter int unsigned p_pack  = DEF_PACK,
   parameter int unsigned p_depth = DEF_DEPTH
) (
   input logic                i_clk,
   input logic                i_rst_n,
   shiftbuffer_drain_if.slave bus
);

   localparam int unsigned BW = p_width * p_pack;
   localparam int unsigned CW = $clog2(p_pack + 1);
   localparam int unsigned LW = $clog2(p_depth + 1);
   localparam int unsigned EW = BW + CW;

   logic [BW-1:0] beat_q;
   logic [BW-1:0] beat_d;
   logic [CW-1:0] pack_q;
   logic [CW-1:0] pack_d;
   logic [CW-1:0] fill;
   logic          flush_q;
   logic          flush_d;
   logic          stall_q;
   logic          stall_d;
   logic          acc;
   logic          full_beat;
   logic          flush_req;
   logic          push;
   logic          pop;
   logic [EW-1:0] fifo_dout;
   logic [LW-1:0] level;
   logic [LW-1:0] level_d;
   logic          empty;

   always_comb begin
      acc    = bus.in_valid & ~stall_q;
      beat_d = beat_q;
      if (acc) begin
         beat_d[int'(pack_q)*p_width +: p_width] = bus.in;
      end
      // words in the packer including this cycle's word
      fill      = pack_q + CW'(acc);
      full_beat = acc & (pack_q == CW'(p_pack - 1));
      flush_req = flush_q | bus.i_flush;
      push      = full_beat;
      flush_d   = 1'b0;
      // a partial beat waits for room; an empty packer drops the flush
      if (!full_beat && flush_req && fill != '0) begin
         if (level < LW'(p_depth)) push = 1'b1;
         else                      flush_d = 1'b1;
      end
      pack_d  = push ? '0 : fill;
      pop     = ~empty & bus.out_ready;
      level_d = level + LW'(push) - LW'(pop);
      // stall only when the next word would complete a beat into a full queue
      stall_d = (level_d == LW'(p_depth)) &
                (pack_d == CW'(p_pack - 1));
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         beat_q  <= '0;
         pack_q  <= '0;
         flush_q <= 1'b0;
         stall_q <= 1'b0;
      end else begin
         beat_q  <= push ? '0 : beat_d;
         pack_q  <= pack_d;
         flush_q <= flush_d;
         stall_q <= stall_d;
      end
   end

   shiftbuffer_drain_beat_fifo #(
      .p_ew    (EW),
      .p_depth (p_depth)
   ) u_fifo (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .i_push  (push),
      .i_data  ({fill, beat_d}),
      .i_pop   (pop),
      .o_data  (fifo_dout),
      .o_count (level),
      .o_empty (empty)
   );

   assign bus.o_stall   = stall_q;
   assign bus.out_valid = ~empty;
   assign bus.out       = empty ? '0 : fifo_dout[BW-1:0];
   assign bus.out_cnt   = empty ? '0 : fifo_dout[EW-1:BW];
   assign bus.o_level   = level;

endmodule

// File: tb/tb_shiftbuffer_drain.sv
// Self-checking bench for shiftbuffer_drain (W=8, P=2, D=2).
// Queue-based reference model plus directed literal beat checks.
module tb_shiftbuffer_drain;

   localparam int W = 8;
   localparam int P = 2;
   localparam int D = 2;

   logic i_clk   = 1'b0;
   logic i_rst_n = 1'b0;

   shiftbuffer_drain_if #(.p_width(W), .p_pack(P), .p_depth(D)) bus ();

   shiftbuffer_drain #(.p_width(W), .p_pack(P), .p_depth(D)) dut (
      .i_clk   (i_clk),
      .i_rst_n (i_rst_n),
      .bus     (bus)
   );

   always #5 i_clk = ~i_clk;

   int checks   = 0;
   int failures = 0;

   task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic [P*W-1:0] data;
      int             cnt;
   } beat_t;

   typedef struct {
      logic [P*W-1:0] data;
      int             cnt;
      int             cyc;
   } ev_t;

   beat_t        mq[$];
   logic [W-1:0] part[$];
   ev_t          evq[$];
   bit           m_fp;
   bit           m_stall;
   bit           up_took;
   int           cyc = 0;

   bit    m_acc, m_pop, m_fr, m_push;
   int    m_lvl;
   beat_t m_b;

   function automatic logic [P*W-1:0] pack_words(input logic [W-1:0] q[$]);
      logic [P*W-1:0] d;
      d = '0;
      for (int i = 0; i < q.size(); i++) d[i*W +: W] = q[i];
      return d;
   endfunction

   // reference model: words gather in a list, beats in a queue
   always @(posedge i_clk) begin
      cyc++;
      up_took = i_rst_n && bus.in_valid && !bus.o_stall;
      if (!i_rst_n) begin
         mq.delete();
         part.delete();
         m_fp    = 0;
         m_stall = 0;
      end else begin
         m_lvl = mq.size();
         m_acc = bus.in_valid && !m_stall;
         m_pop = (m_lvl > 0) && bus.out_ready;
         m_fr  = m_fp || bus.i_flush;
         if (m_acc) part.push_back(bus.in);
         m_push = 0;
         if (part.size() == P) begin
            m_push = 1;
            m_fp   = 0;
         end else if (m_fr && part.size() == 0) begin
            m_fp = 0;
         end else if (m_fr && m_lvl < D) begin
            m_push = 1;
            m_fp   = 0;
         end else begin
            m_fp = m_fr;
         end
         if (m_push) begin
            m_b.data = pack_words(part);
            m_b.cnt  = part.size();
            part.delete();
         end
         if (m_pop) void'(mq.pop_front());
         if (m_push) begin
            chk("fifo_room", 32'(mq.size() < D), 1);
            mq.push_back(m_b);
         end
         m_stall = (mq.size() == D) && (part.size() == P - 1);
      end
   end

   // compare every cycle
   always @(negedge i_clk) begin
      chk("out_valid", 32'(bus.out_valid), 32'(mq.size() > 0));
      chk("o_level", 32'(bus.o_level), mq.size());
      chk("o_stall", 32'(bus.o_stall), 32'(m_stall));
      if (mq.size() > 0) begin
         chk("out", 32'(bus.out), 32'(mq[0].data));
         chk("out_cnt", 32'(bus.out_cnt), mq[0].cnt);
      end else begin
         chk("out_idle", 32'(bus.out), 0);
         chk("out_cnt_idle", 32'(bus.out_cnt), 0);
      end
      if (bus.out_valid && bus.out_ready)
         evq.push_back('{data: bus.out, cnt: int'(bus.out_cnt), cyc: cyc});
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic send(logic [W-1:0] w, logic fl);
      int n;
      bus.in       = w;
      bus.in_valid = 1'b1;
      bus.i_flush  = fl;
      n = 0;
      do begin
         tick();
         n++;
      end while (!up_took && n < 20);
      chk("send_taken", 32'(up_took), 1);
      bus.in_valid = 1'b0;
      bus.i_flush  = 1'b0;
   endtask

   task automatic check_ev(string n, int idx, logic [P*W-1:0] d, int c);
      chk({n, "_present"}, 32'(evq.size() > idx), 1);
      if (evq.size() > idx) begin
         chk({n, "_data"}, 32'(evq[idx].data), 32'(d));
         chk({n, "_cnt"}, evq[idx].cnt, c);
      end
   endtask

   int c0;

   initial begin
      bus.in        = '0;
      bus.in_valid  = 1'b0;
      bus.i_flush   = 1'b0;
      bus.out_ready = 1'b0;

      // reset with upstream offering a word
      i_rst_n      = 1'b0;
      bus.in_valid = 1'b1;
      bus.in       = 8'hEE;
      tick();
      tick();
      chk("rst_stall", 32'(bus.o_stall), 0);
      chk("rst_valid", 32'(bus.out_valid), 0);
      chk("rst_level", 32'(bus.o_level), 0);
      bus.in_valid = 1'b0;
      i_rst_n      = 1'b1;
      tick();

      // basic stream, beat one cycle after its second word
      bus.out_ready = 1'b1;
      evq.delete();
      c0 = cyc;
      send(8'h11, 0);
      send(8'h22, 0);
      send(8'h33, 0);
      send(8'h44, 0);
      repeat (3) tick();
      check_ev("t2_b0", 0, 16'h2211, 2);
      check_ev("t2_b1", 1, 16'h4433, 2);
      if (evq.size() > 1) begin
         chk("t2_lat0", evq[0].cyc - c0, 2);
         chk("t2_lat1", evq[1].cyc - c0, 4);
      end

      // back-pressure: sixth word held until one pop frees room
      bus.out_ready = 1'b0;
      evq.delete();
      for (int i = 1; i <= 5; i++) send(8'(i), 0);
      chk("t3_level", 32'(bus.o_level), 2);
      chk("t3_stall", 32'(bus.o_stall), 1);
      bus.in       = 8'h06;
      bus.in_valid = 1'b1;
      tick();
      chk("t3_held0", 32'(up_took), 0);
      tick();
      chk("t3_held1", 32'(up_took), 0);
      bus.out_ready = 1'b1;
      tick();
      chk("t3_held2", 32'(up_took), 0);
      chk("t3_stall_drop", 32'(bus.o_stall), 0);
      bus.out_ready = 1'b0;
      tick();
      chk("t3_took6", 32'(up_took), 1);
      bus.in_valid = 1'b0;
      chk("t3_level2", 32'(bus.o_level), 2);
      tick();
      bus.out_ready = 1'b1;
      repeat (4) tick();
      chk("t3_nbeats", evq.size(), 3);
      check_ev("t3_b0", 0, 16'h0201, 2);
      check_ev("t3_b1", 1, 16'h0403, 2);
      check_ev("t3_b2", 2, 16'h0605, 2);

      // flush with same-cycle word, then flush alone
      evq.delete();
      send(8'hAA, 0);
      send(8'hBB, 1);
      send(8'hCC, 0);
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      repeat (3) tick();
      chk("t4_nbeats", evq.size(), 2);
      check_ev("t4_b0", 0, 16'hBBAA, 2);
      check_ev("t4_b1", 1, 16'h00CC, 1);

      // flush pending against a full queue
      bus.out_ready = 1'b0;
      evq.delete();
      for (int i = 1; i <= 5; i++) send(8'(8'h70 + i), 0);
      bus.i_flush = 1'b1;
      tick();
      bus.i_flush = 1'b0;
      tick();
      tick();
      chk("t5_nopush", 32'(bus.o_level), 2);
      chk("t5_stall", 32'(bus.o_stall), 1);
      bus.out_ready = 1'b1;
      repeat (5) tick();
      chk("t5_nbeats", evq.size(), 3);
      check_ev("t5_b2", 2, 16'h0075, 1);

      // reset mid-operation drops everything
      bus.out_ready = 1'b0;
      evq.delete();
      for (int i = 1; i <= 5; i++) send(8'(8'h80 + i), 0);
      i_rst_n = 1'b0;
      tick();
      chk("t6_valid", 32'(bus.out_valid), 0);
      chk("t6_stall", 32'(bus.o_stall), 0);
      chk("t6_level", 32'(bus.o_level), 0);
      i_rst_n       = 1'b1;
      bus.out_ready = 1'b1;
      send(8'h5A, 0);
      send(8'h5B, 0);
      repeat (2) tick();
      check_ev("t6_b0", 0, 16'h5B5A, 2);

      // randomized traffic, model compare only
      for (int i = 0; i < 3000; i++) begin
         if (!(bus.in_valid && !up_took)) begin
            bus.in_valid = ($urandom_range(0, 99) < 65);
            bus.in       = 8'($urandom);
         end
         bus.i_flush   = ($urandom_range(0, 99) < 8);
         bus.out_ready = ($urandom_range(0, 99) < ((i / 500) % 2 == 0 ? 30 : 80));
         i_rst_n       = ($urandom_range(0, 999) >= 4);
         tick();
      end
      i_rst_n      = 1'b1;
      bus.in_valid = 1'b0;
      bus.i_flush  = 1'b0;
      repeat (4) tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
